// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_nibble.sv
// Combinational 4-bit adder slice with carry in/out; the only adder in the serial datapath.
module add_nibble
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] res,
  output logic             cout
);

  assign {cout, res} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder processing one nibble per clock, LSB first, with valid/ready on both sides.
// Optional macro ADDER_SUB_EN adds a `sub` input that turns the operation into a - b.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry, cout_q;
  logic [IDX_W-1:0] idx;
  logic [NIB_W-1:0] a_nib, b_nib, s_nib;
  logic             c_nib;
  logic             accept, last;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the serial datapath is unchanged.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state == DONE);
  assign res       = res_q;
  assign cout      = cout_q;
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDX_W'(NIB - 1));

  assign a_nib = a_q[idx*NIB_W +: NIB_W];
  assign b_nib = b_q[idx*NIB_W +: NIB_W];

  add_nibble u_add_nibble (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .res  (s_nib),
    .cout (c_nib)
  );

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b_in;
        carry <= c_in;
        idx   <= '0;
        res_q <= '0;  // nibbles not yet computed read as zero during RUN
      end else if (state == RUN) begin
        res_q[idx*NIB_W +: NIB_W] <= s_nib;
        carry                     <= c_nib;
        if (last) begin
          cout_q <= c_nib;
          idx    <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus randomized operands
// against an arithmetic reference model. Build with ADDER_SUB_EN to exercise subtraction.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] res;
  logic             cout, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole word; bit WIDTH is the carry out.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic ci, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
  endfunction

  // Present one operation, track its progress, optionally stall the consumer, then hand off.
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic ci, input logic sb, input int hold, input string tag);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] mask;
    int               cycles;
    exp = ref_sum(xa, xb, ci, sb);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; cin = ci; sub = sb;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!out_valid && cycles < 3 * NIB) begin
      @(negedge clk);
      cycles++;
      if (!out_valid) begin
        mask = (WIDTH'(1) << (4 * cycles)) - WIDTH'(1);
        check({tag, ".partial"}, 32'(res), 32'(exp[WIDTH-1:0] & mask));
      end
    end
    check({tag, ".latency"}, cycles, NIB);
    check({tag, ".res"}, 32'(res), 32'(exp[WIDTH-1:0]));
    check({tag, ".cout"}, 32'(cout), 32'(exp[WIDTH]));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      check({tag, ".hold_res"}, 32'(res), 32'(exp[WIDTH-1:0]));
      check({tag, ".hold_valid"}, 32'({out_valid, in_ready}), 32'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".handoff"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    logic [WIDTH:0] exp;
    int             cycles;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset.flags", 32'({in_ready, out_valid, busy}), 32'b100);
    check("reset.res", 32'({cout, res}), 32'd0);

    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, "add_small");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "wrap");
    do_op(16'h0003, 16'h0002, 1'b1, 1'b0, 3, "backpressure");

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00F0; b = 16'h0F10; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 3 * NIB) begin @(negedge clk); cycles++; end
    check("b2b.first_res", 32'(res), 32'h1000);
    @(negedge clk);
    check("b2b.in_ready_next", 32'({in_ready, out_valid}), 32'b10);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 3 * NIB) begin @(negedge clk); cycles++; end
    check("b2b.latency", cycles, NIB);
    check("b2b.second_res", 32'({cout, res}), 32'h05555);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while two nibbles have been computed.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h7777; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.res", 32'({cout, res}), 32'd0);
    check("midreset.flags", 32'({in_ready, out_valid, busy}), 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0A0B, 16'h0102, 1'b1, 1'b0, 0, "after_reset");

`ifdef ADDER_SUB_EN
    do_op(16'h0005, 16'h0003, 1'b0, 1'b1, 0, "sub_pos");
    do_op(16'h0003, 16'h0005, 1'b1, 1'b1, 0, "sub_neg");
`endif

    for (int i = 0; i < 30; i++) begin
      logic sb;
`ifdef ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sb, int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
